// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN = 1'b0,
    DIV = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic pc_load;
    logic ifid_load;
    logic idex_load;
    logic exmem_load;
    logic memwb_load;
    logic ifid_clear;
    logic idex_clear;
    logic exmem_clear;
    logic memwb_clear;
  } pipe_ctrl_t;

  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator; shared with the forwarding unit.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  output logic            load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rd != RA_W'(REG_X0)) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer: drives load/clear of PC and pipeline registers
// for load-use, redirects, multi-cycle divide and data-memory wait states.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_div,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_clear,
  output logic             idex_clear,
  output logic             exmem_clear,
  output logic             memwb_clear,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned        DCNT_W    = $clog2(DIV_CYCLES);
  localparam logic [DCNT_W-1:0]  DCNT_LOAD = DCNT_W'(DIV_CYCLES - 2);

  ctrl_state_t       state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  pipe_ctrl_t        ctrl, ctrl_out;
  logic              busy, done, load_use, mem_wait;

  hazard_detect #(
    .RA_W (RA_W)
  ) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    mem_wait = mem_req && !mem_ready;
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    ctrl     = '{pc_load: 1'b1, ifid_load: 1'b1, idex_load: 1'b1,
                 exmem_load: 1'b1, memwb_load: 1'b1, default: 1'b0};

    // The divider keeps counting even under a mem wait; only the exit to RUN
    // waits for the memory to release.
    if (state_q == DIV) begin
      busy = 1'b1;
      if (dcnt_q != '0) begin
        dcnt_d = dcnt_q - DCNT_W'(1);
      end else begin
        done = 1'b1;
        if (!mem_wait) state_d = RUN;
      end
    end

    if (mem_wait) begin
      ctrl.pc_load     = 1'b0;
      ctrl.ifid_load   = 1'b0;
      ctrl.idex_load   = 1'b0;
      ctrl.exmem_load  = 1'b0;
      ctrl.memwb_clear = 1'b1;
    end else if (state_q == DIV) begin
      if (dcnt_q != '0) begin
        ctrl.pc_load     = 1'b0;
        ctrl.ifid_load   = 1'b0;
        ctrl.idex_load   = 1'b0;
        ctrl.exmem_clear = 1'b1;
      end
    end else if (ex_div) begin
      ctrl.pc_load     = 1'b0;
      ctrl.ifid_load   = 1'b0;
      ctrl.idex_load   = 1'b0;
      ctrl.exmem_clear = 1'b1;
      busy             = 1'b1;
      dcnt_d           = DCNT_LOAD;
      state_d          = DIV;
    end else if (ex_redirect) begin
      ctrl.ifid_clear = 1'b1;
      ctrl.idex_clear = 1'b1;
    end else if (load_use) begin
      ctrl.pc_load    = 1'b0;
      ctrl.ifid_load  = 1'b0;
      ctrl.idex_clear = 1'b1;
    end

    stall_cnt_d = stall_cnt_q + CNT_W'(!ctrl.pc_load);
    flush_cnt_d = flush_cnt_q + CNT_W'(ctrl.ifid_clear);

    // Reset forces every register to hold a bubble, independent of the clock.
    if (rst_n) begin
      ctrl_out = ctrl;
    end else begin
      ctrl_out = '{ifid_clear: 1'b1, idex_clear: 1'b1, exmem_clear: 1'b1,
                   memwb_clear: 1'b1, default: 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      dcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_load     = ctrl_out.pc_load;
  assign ifid_load   = ctrl_out.ifid_load;
  assign idex_load   = ctrl_out.idex_load;
  assign exmem_load  = ctrl_out.exmem_load;
  assign memwb_load  = ctrl_out.memwb_load;
  assign ifid_clear  = ctrl_out.ifid_clear;
  assign idex_clear  = ctrl_out.idex_clear;
  assign exmem_clear = ctrl_out.exmem_clear;
  assign memwb_clear = ctrl_out.memwb_clear;
  assign div_busy    = rst_n && busy;
  assign div_done    = rst_n && done;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
